// File: rtl/tempo_pkg.sv
// Shared types and board-derived defaults for the tempo button conditioner.
package tempo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HELD   = 2'd3
    } key_state_t;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_UP    = 2;

    // 100 MHz board clock: 2.5 ms debounce, 0.5 s repeat delay, 10 Hz repeat.
    localparam int unsigned CLK_HZ               = 100_000_000;
    localparam int unsigned DEBOUNCE_CYC_DEF     = CLK_HZ / 400;
    localparam int unsigned REPEAT_DELAY_CYC_DEF = CLK_HZ / 2;
    localparam int unsigned REPEAT_RATE_CYC_DEF  = CLK_HZ / 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: 2-flop synchronizer, debounce counter and press/repeat FSM.
module key_channel
    import tempo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = DEBOUNCE_CYC_DEF,
    parameter int unsigned REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEF,
    parameter int unsigned REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEF,
    parameter bit          REPEAT_EN        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_pulse,
    output logic btn_level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TW = max_u($clog2(max_u(REPEAT_DELAY_CYC, REPEAT_RATE_CYC)), 1);

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY_CYC - 1);
    localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE_CYC - 1);

    if (DEBOUNCE_CYC < 1) begin : g_chk_debounce
        $error("DEBOUNCE_CYC must be >= 1");
    end
    if (REPEAT_DELAY_CYC < 2) begin : g_chk_delay
        $error("REPEAT_DELAY_CYC must be >= 2");
    end
    if (REPEAT_RATE_CYC < 2) begin : g_chk_rate
        $error("REPEAT_RATE_CYC must be >= 2");
    end

    logic          s1, s2, stable;
    logic [CW-1:0] cnt;
    logic          flip, rise, fall;

    key_state_t    state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic          pulse_next;

    // The FSM reacts on the same edge that flips stable, so level and pulse rise together.
    assign flip = (s2 != stable) && (cnt == DB_LAST);
    assign rise = flip && s2;
    assign fall = flip && !s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            stable    <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
            timer     <= '0;
            btn_pulse <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            state     <= state_next;
            timer     <= timer_next;
            btn_pulse <= pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        pulse_next = 1'b0;
        if (fall) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        pulse_next = 1'b1;
                        state_next = REPEAT_EN ? DELAY : HELD;
                        timer_next = DELAY_LOAD;
                    end
                end
                DELAY, REPEAT: begin
                    if (timer == '0) begin
                        pulse_next = 1'b1;
                        timer_next = RATE_LOAD;
                        state_next = REPEAT;
                    end else begin
                        timer_next = timer - TW'(1);
                    end
                end
                HELD: ;
                default: state_next = IDLE;
            endcase
        end
    end

    assign btn_level = stable;

endmodule

// File: rtl/tempo_keys.sv
// Button conditioner feeding freq: one independent key_channel per button.
module tempo_keys
    import tempo_pkg::*;
#(
    parameter int unsigned      N_BTN            = 3,
    parameter int unsigned      DEBOUNCE_CYC     = DEBOUNCE_CYC_DEF,
    parameter int unsigned      REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEF,
    parameter int unsigned      REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEF,
    parameter logic [N_BTN-1:0] REPEAT_MASK      = 3'b011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_level
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
            .REPEAT_EN        (REPEAT_MASK[i])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[i]),
            .btn_pulse (btn_pulse[i]),
            .btn_level (btn_level[i])
        );
    end

endmodule

// File: tb/tb_tempo_keys.sv
// Directed bench for tempo_keys with short debounce/repeat timings.
module tb_tempo_keys;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_in = '0;
    logic [2:0] btn_pulse;
    logic [2:0] btn_level;

    int total = 0;
    int bad   = 0;

    tempo_keys #(
        .N_BTN            (3),
        .DEBOUNCE_CYC     (4),
        .REPEAT_DELAY_CYC (20),
        .REPEAT_RATE_CYC  (8),
        .REPEAT_MASK      (3'b011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive inputs for the next edge, then sample 1 time unit after it.
    task automatic step(input logic [2:0] in);
        btn_in = in;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_check(input string tag, input int e, input logic [2:0] ep, input logic [2:0] el);
        check($sformatf("%s_pulse@%0d", tag, e), {5'b0, btn_pulse}, {5'b0, ep});
        check($sformatf("%s_level@%0d", tag, e), {5'b0, btn_level}, {5'b0, el});
    endtask

    task automatic do_reset(input string tag);
        rst    = 1'b1;
        btn_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, "_rst_pulse"}, {5'b0, btn_pulse}, 8'd0);
        check({tag, "_rst_level"}, {5'b0, btn_level}, 8'd0);
    endtask

    initial begin
        logic [2:0] ep, el;

        // Clean press on left with repeats, then release suppressing the repeat at 65.
        do_reset("clean");
        for (int e = 0; e <= 70; e++) begin
            step((e <= 59) ? 3'b001 : 3'b000);
            ep = (e == 5 || e == 25 || e == 33 || e == 41 || e == 49 || e == 57) ? 3'b001 : 3'b000;
            el = (e >= 5 && e <= 64) ? 3'b001 : 3'b000;
            cycle_check("clean", e, ep, el);
        end

        // Bounce on right: 2-high/2-low for 20 cycles, then held from edge 20.
        do_reset("bounce");
        for (int e = 0; e <= 50; e++) begin
            step((e >= 20 || (e % 4) < 2) ? 3'b010 : 3'b000);
            ep = (e == 25 || e == 45) ? 3'b010 : 3'b000;
            el = (e >= 25) ? 3'b010 : 3'b000;
            cycle_check("bounce", e, ep, el);
        end

        // Up does not repeat.
        do_reset("norep");
        for (int e = 0; e <= 110; e++) begin
            step((e <= 99) ? 3'b100 : 3'b000);
            ep = (e == 5) ? 3'b100 : 3'b000;
            el = (e >= 5 && e <= 104) ? 3'b100 : 3'b000;
            cycle_check("norep", e, ep, el);
        end

        // Simultaneous left + right.
        do_reset("simul");
        for (int e = 0; e <= 30; e++) begin
            step(3'b011);
            ep = (e == 5 || e == 25) ? 3'b011 : 3'b000;
            el = (e >= 5) ? 3'b011 : 3'b000;
            cycle_check("simul", e, ep, el);
        end

        // Reset at edge 22 while left is held; fresh press pulse at 28.
        do_reset("midrst");
        for (int e = 0; e <= 35; e++) begin
            rst = (e == 22);
            step(3'b001);
            ep = (e == 5 || e == 28) ? 3'b001 : 3'b000;
            el = ((e >= 5 && e <= 21) || e >= 28) ? 3'b001 : 3'b000;
            cycle_check("midrst", e, ep, el);
        end
        rst = 1'b0;

        // 3-cycle glitch is filtered.
        do_reset("glitch");
        for (int e = 0; e <= 15; e++) begin
            step((e <= 2) ? 3'b001 : 3'b000);
            cycle_check("glitch", e, 3'b000, 3'b000);
        end

        // Exactly DEBOUNCE_CYC cycles high is accepted; release after same latency.
        do_reset("edge4");
        for (int e = 0; e <= 15; e++) begin
            step((e <= 3) ? 3'b001 : 3'b000);
            ep = (e == 5) ? 3'b001 : 3'b000;
            el = (e >= 5 && e <= 8) ? 3'b001 : 3'b000;
            cycle_check("edge4", e, ep, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
